// File: rtl/div_pkg.sv
// Shared FSM encoding and default sizing for the divided-clock ratio detector.
package div_pkg;

   localparam int CNT_W_DEF  = 8;
   localparam int LOCK_N_DEF = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } state_e;

endpackage

// File: rtl/div_ratio_detect_if.sv
// Measurement bus: sig_in toward the detector, ratio/status back out; no backpressure.
interface div_ratio_detect_if
   import div_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
);

   logic             sig_in;
   logic [CNT_W-1:0] ratio;
   logic             valid;
   logic             locked;
   logic             err;

   modport master (
      output sig_in,
      input  ratio,
      input  valid,
      input  locked,
      input  err
   );

   modport slave (
      input  sig_in,
      output ratio,
      output valid,
      output locked,
      output err
   );

endinterface

// File: rtl/edge_det.sv
// Two-flop sampler of d with a registered rising-edge flag; rise is one cycle wide, 2 clk after d rises.
module edge_det (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic sig_q,  sig_d;
   logic sig_qq, sig_qq_d;
   logic rise_q, rise_d;

   always_comb begin
      sig_d    = d;
      sig_qq_d = sig_q;
      rise_d   = sig_q & ~sig_qq;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sig_q  <= 1'b0;
         sig_qq <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sig_q  <= sig_d;
         sig_qq <= sig_qq_d;
         rise_q <= rise_d;
      end
   end

   assign rise = rise_q;

endmodule

// File: rtl/div_ratio_detect.sv
// Measures the period of a clk-synchronous divided clock and flags lock/loss; ratio/valid
// update 3 clk after a sig_in rising transition; no backpressure, results are pulsed once.
module div_ratio_detect
   import div_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int LOCK_N = LOCK_N_DEF
) (
   input  logic                clk,
   input  logic                rst,
   div_ratio_detect_if.slave   bus
);

   localparam int MATCH_W = $clog2(LOCK_N + 1);

   localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [MATCH_W-1:0] MATCH_ONE = {{(MATCH_W-1){1'b0}}, 1'b1};
   localparam logic [MATCH_W-1:0] MATCH_SAT = MATCH_W'(LOCK_N);

   logic                rise;

   state_e              state_q,  state_d;
   logic [CNT_W-1:0]    cnt_q,    cnt_d;
   logic [CNT_W-1:0]    ratio_q,  ratio_d;
   logic                valid_q,  valid_d;
   logic                locked_q, locked_d;
   logic                err_q,    err_d;
   logic [MATCH_W-1:0]  match_q,  match_d;

   logic                period_match;
   logic [MATCH_W-1:0]  match_inc;

   edge_det u_edge_det (
      .clk  (clk),
      .rst  (rst),
      .d    (bus.sig_in),
      .rise (rise)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ratio_d  = ratio_q;
      valid_d  = 1'b0;
      locked_d = locked_q;
      err_d    = 1'b0;
      match_d  = match_q;

      period_match = (cnt_q == ratio_q);
      match_inc    = (match_q >= MATCH_SAT) ? MATCH_SAT : (match_q + MATCH_ONE);

      case (state_q)
         IDLE: begin
            // First edge only opens the measurement window; there is no period yet.
            cnt_d = CNT_ONE;
            if (rise) begin
               state_d = MEASURE;
            end
         end

         MEASURE, LOCKED: begin
            if (rise) begin
               ratio_d = cnt_q;
               valid_d = 1'b1;
               cnt_d   = CNT_ONE;
               if (period_match) begin
                  match_d = match_inc;
                  if (match_inc == MATCH_SAT) begin
                     state_d  = LOCKED;
                     locked_d = 1'b1;
                  end
               end else begin
                  match_d = MATCH_ONE;
                  if (state_q == LOCKED) begin
                     err_d    = 1'b1;
                     locked_d = 1'b0;
                     state_d  = MEASURE;
                  end
               end
            end else if (cnt_q == CNT_MAX) begin
               // Lost input: keep the last good ratio but restart from scratch.
               err_d    = 1'b1;
               locked_d = 1'b0;
               match_d  = '0;
               cnt_d    = CNT_ONE;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = CNT_ONE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= CNT_ONE;
         ratio_q  <= '0;
         valid_q  <= 1'b0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
         match_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ratio_q  <= ratio_d;
         valid_q  <= valid_d;
         locked_q <= locked_d;
         err_q    <= err_d;
         match_q  <= match_d;
      end
   end

   assign bus.ratio  = ratio_q;
   assign bus.valid  = valid_q;
   assign bus.locked = locked_q;
   assign bus.err    = err_q;

endmodule

// File: doc/div_ratio_detect.md
DIV_RATIO_DETECT -- requirements
Module: div_ratio_detect

Interface
REQ-001 Parameter CNT_W, default 8: width of the period counter and of ratio.
REQ-002 Parameter LOCK_N, default 3: number of consecutive equal periods required to lock.
REQ-003 Port clk  input  1: single clock; all logic is rising-edge.
REQ-004 Port rst  input  1: asynchronous, active-low reset.
REQ-005 Port sig_in  input  1: divided clock under test, generated synchronously from clk (e.g. a divide-by-4 output).
REQ-006 Port ratio  output  CNT_W: last measured period of sig_in, in clk cycles.
REQ-007 Port valid  output  1: one-cycle pulse when ratio is updated.
REQ-008 Port locked  output  1: high while LOCK_N+ consecutive periods are equal.
REQ-009 Port err  output  1: one-cycle pulse on a period change while locked, or on timeout.

Function
REQ-010 sig_in shall be registered twice (sig_q, sig_qq); a rising edge is detected when sig_q=1 and sig_qq=0.
REQ-011 The FSM shall have the states IDLE, MEASURE and LOCKED.
REQ-012 IDLE: the counter is held at 1; on the first detected edge the FSM goes to MEASURE with no valid pulse.
REQ-013 MEASURE/LOCKED: the counter shall increment by 1 per clk; on an edge, ratio shall take the counter value, valid shall pulse in the same cycle ratio updates, and the counter shall reload to 1.
REQ-014 Latency: ratio and valid shall update on the clock edge following the cycle in which the edge was detected, i.e. 3 clk after the sig_in transition.
REQ-015 Match counter: it shall increment when a new period equals the previous ratio, saturate at LOCK_N, and reload to 1 on a mismatch.
REQ-016 MEASURE goes to LOCKED when the match counter reaches LOCK_N; locked is asserted in that same update cycle.
REQ-017 LOCKED: on a mismatching period, err shall pulse, locked shall deassert, the new ratio shall still be reported with valid, and the FSM shall go to MEASURE.
REQ-018 Timeout: if the counter reaches 2^CNT_W-1 without an edge, err shall pulse, locked shall clear, ratio shall be unchanged, valid shall not pulse, and the FSM shall go to IDLE.
REQ-019 The counter shall never wrap; the timeout takes precedence over any further increment.
REQ-020 An edge and a timeout in the same cycle shall be treated as an edge.
REQ-021 The minimum measurable ratio is 2 (sig_in toggling every clk); no special handling is needed for it.
REQ-022 Simultaneous valid and err are legal only in the REQ-017 case.

Reset
REQ-023 While rst=0: the FSM is in IDLE; ratio=0, valid=0, locked=0, err=0; counter=1; match counter=0; sig_q=sig_qq=0.
REQ-024 Reset asserted mid-measurement or while locked shall take effect immediately (asynchronously), with no err pulse.
REQ-025 After rst rises, the first edge shall be treated as in REQ-012.

Structure
REQ-026 The FSM state encoding (IDLE, MEASURE, LOCKED) and the default values for CNT_W and LOCK_N shall live in a shared package, div_pkg.
REQ-027 Rising-edge detection shall be one sub-module, edge_det (clk, rst, d, rise); the rest shall be flat in div_ratio_detect.
REQ-028 Implementation size shall be 120-400 lines of RTL.

Verification
REQ-029 Reset sequence: rst=0 for 20 ns -> all outputs 0; then release rst and run for 200 ns as the baseline.
REQ-030 sig_in driven as clk/4 after reset -> valid pulses every 4 clk with ratio=4; locked=1 at the 3rd valid pulse; err never asserted.
REQ-031 Locked at ratio 4, then switch sig_in to clk/6 -> one err pulse together with valid at ratio=6 and locked=0; locked=1 again after 3 periods of 6.
REQ-032 Locked at ratio 4, then hold sig_in=0 -> err pulse 255 clk after the last reload, locked=0, ratio stays 4, FSM in IDLE.
REQ-033 Assert rst for 1 cycle mid-lock at clk/4 -> outputs 0 immediately with no err; relock with ratio=4 after the 1st edge plus 3 periods.
REQ-034 sig_in toggling every clk (clk/2) -> ratio=2 on every valid pulse; locked asserted after 3 periods.
